half_adder_rca4: RTL and testbench

HALF_ADDER_RCA4 -- requirements
Module: half_adder_rca4

---
 rtl/half_adder_rca4.sv | 76 +++++++
 tb/tb_half_adder_rca4.sv | 120 ++++++++++++
 2 files changed

// File: rtl/half_adder_rca4.sv
// Registered carry-increment adder: group 0 ripples from Cin, each higher group
// adds with carry-in 0 and then absorbs the incoming carry through a half-adder chain.
module half_adder_rca4 #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    localparam int NGROUPS = WIDTH / GROUP;

    logic [NGROUPS:0]  group_carry;
    logic [WIDTH-1:0]  sum_comb;

    assign group_carry[0] = Cin;

    genvar g, b;
    generate
        for (g = 0; g < NGROUPS; g++) begin : grp
            logic [GROUP:0] rc;

            if (g == 0) begin : g_first
                assign rc[0] = group_carry[0];
                for (b = 0; b < GROUP; b++) begin : fa
                    assign sum_comb[b] = A[b] ^ B[b] ^ rc[b];
                    assign rc[b+1]     = (A[b] & B[b]) | (A[b] & rc[b]) | (B[b] & rc[b]);
                end
                assign group_carry[1] = rc[GROUP];
            end else begin : g_incr
                logic [GROUP-1:0] p;
                logic [GROUP:0]   hc;

                assign rc[0] = 1'b0;
                for (b = 0; b < GROUP; b++) begin : fa
                    assign p[b]    = A[g*GROUP+b] ^ B[g*GROUP+b] ^ rc[b];
                    assign rc[b+1] = (A[g*GROUP+b] & B[g*GROUP+b])
                                   | (A[g*GROUP+b] & rc[b])
                                   | (B[g*GROUP+b] & rc[b]);
                end

                // Incoming carry ripples through the partial sum as an increment.
                assign hc[0] = group_carry[g];
                for (b = 0; b < GROUP; b++) begin : ha
                    assign sum_comb[g*GROUP+b] = hc[b] ^ p[b];
                    assign hc[b+1]             = hc[b] & p[b];
                end

                // The increment and the local add can never both carry out.
                assign group_carry[g+1] = hc[GROUP] | rc[GROUP];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S         <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum_comb;
                Cout <= group_carry[NGROUPS];
            end
        end
    end

endmodule

// File: tb/tb_half_adder_rca4.sv
// Directed and randomized checks of half_adder_rca4 against plain A+B+Cin arithmetic.
module tb_half_adder_rca4;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

    int total = 0;
    int bad   = 0;

    half_adder_rca4 #(.WIDTH(WIDTH), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = c;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH:0] obs,
                               input logic [WIDTH:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH:0] exp_sum,
                               input logic exp_valid);
        checkOutput({tag, ".S"},         {1'b0, S},          {1'b0, exp_sum[WIDTH-1:0]});
        checkOutput({tag, ".Cout"},      {{WIDTH{1'b0}}, Cout},      {{WIDTH{1'b0}}, exp_sum[WIDTH]});
        checkOutput({tag, ".out_valid"}, {{WIDTH{1'b0}}, out_valid}, {{WIDTH{1'b0}}, exp_valid});
    endtask

    task automatic stepAndCheck(input string tag, input logic v,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic c, input logic [WIDTH:0] exp_sum,
                                input logic exp_valid);
        applyStimulus(v, a, b, c);
        @(posedge clk);
        #1;
        checkResult(tag, exp_sum, exp_valid);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;

        rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #1 rst = 1'b1;
        #1 checkResult("reset", 9'h000, 1'b0);

        // Edge with valid data under reset must be ignored.
        in_valid = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
        @(posedge clk); #1;
        checkResult("reset_edge", 9'h000, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        stepAndCheck("incr",       1'b1, 8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
        stepAndCheck("incr_cout",  1'b1, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        stepAndCheck("rca_carry",  1'b1, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
        stepAndCheck("max",        1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        stepAndCheck("cin_only",   1'b1, 8'h00, 8'h00, 1'b1, 9'h001, 1'b1);

        stepAndCheck("hold_load",  1'b1, 8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
        stepAndCheck("hold_1",     1'b0, 8'hFF, 8'hFF, 1'b1, 9'h046, 1'b0);
        stepAndCheck("hold_2",     1'b0, 8'h77, 8'h99, 1'b0, 9'h046, 1'b0);

        // Reset asserted between edges while a result is pending.
        stepAndCheck("stream_0",   1'b1, 8'h55, 8'h22, 1'b0, 9'h077, 1'b1);
        applyStimulus(1'b1, 8'h33, 8'h44, 1'b1);
        #2 rst = 1'b1;
        #1 checkResult("mid_reset", 9'h000, 1'b0);
        @(posedge clk); #1;
        checkResult("mid_reset_edge", 9'h000, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            stepAndCheck("sweep", 1'b1, ra, rb, rc, refSum(ra, rb, rc), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
